// File: rtl/neg_pkg.sv
// Shared types and defaults for the negator-sharing controller.
// NEG_TWOS_COMP_EN (when defined) adds the INC state and two's-complement results.
package neg_pkg;

  localparam int unsigned W_DEF = 16;
  localparam int unsigned N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    INC  = 2'd2,
    RESP = 2'd3
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neg_share_ctrl_if.sv
// Request/response/negator bundle between client blocks and neg_share_ctrl.
// The controller takes the slave view; clients and the negator take the master view.
interface neg_share_ctrl_if #(
  parameter int unsigned N = neg_pkg::N_DEF,
  parameter int unsigned W = neg_pkg::W_DEF
);

  localparam int unsigned IW = neg_pkg::id_width(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   neg_a;
  logic [W-1:0]   neg_b;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic           busy;

  modport slave (
    input  req_valid, req_data, neg_b, rsp_ready,
    output req_ready, neg_a, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_data, neg_b, rsp_ready,
    input  req_ready, neg_a, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/rr_arb.sv
// Combinational N-way round-robin arbiter: first requester after ptr wins, with wrap.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/neg_share_ctrl.sv
// Time-shares one external combinational negator among N requesters.
// NEG_TWOS_COMP_EN selects two's complement (extra INC cycle); default is ones' complement.
module neg_share_ctrl
  import neg_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  neg_share_ctrl_if.slave  bus
);

  localparam int unsigned IW = id_width(N);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  neg_a_q, neg_a_d;
  logic [W-1:0]  res_q, res_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  gnt_c;
  logic [IW-1:0] gnt_idx_c;
  logic          gnt_valid_c;
  logic [N-1:0]  req_ready_c;

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt_c),
    .gnt_idx   (gnt_idx_c),
    .gnt_valid (gnt_valid_c)
  );

  // Next-state and datapath updates; accept strobe is suppressed while reset is asserted.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    neg_a_d     = neg_a_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        if (rst_n && gnt_valid_c) begin
          req_ready_c = gnt_c;
          neg_a_d     = bus.req_data[32'(gnt_idx_c) * W +: W];
          id_d        = gnt_idx_c;
          state_d     = RUN;
        end
      end
      RUN: begin
        res_d = bus.neg_b;
`ifdef NEG_TWOS_COMP_EN
        state_d = INC;
`else
        state_d     = RESP;
        rsp_valid_d = 1'b1;
`endif
      end
`ifdef NEG_TWOS_COMP_EN
      INC: begin
        res_d       = res_q + W'(1);
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d       = id_q;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(N - 1);
      id_q        <= '0;
      neg_a_q     <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      neg_a_q     <= neg_a_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.neg_a     = neg_a_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = busy_q;

endmodule
